fp_add_norm_stage: RTL

// - Post-add normalisation stage of the FP32 add/sub datapath. It sits directly

---
 rtl/fp_add_pkg.sv | 22 ++
 rtl/lopd_32bit.sv | 37 +++
 rtl/fp_add_norm_stage.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fp_add_pkg.sv
// Shared widths and the S1->S2 beat record for the FP32 add normalisation stage.
//   EXP_W   biased exponent width
//   MANT_W  normalised mantissa width (hidden + 23 frac + G,R,S)
//   POS_W   leading-one index width
//   EXP_MAX all-ones exponent (infinity)
package fp_add_pkg;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 27;
    localparam int POS_W  = 5;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    // Raw sum split into carry-out + low MANT_W bits, plus precomputed
    // leading-one index and exact-zero flag.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic              carry;
        logic              zero;
        logic [POS_W-1:0]  pos;
    } norm_beat_t;
endpackage

// File: rtl/lopd_32bit.sv
// Leading-one position detectors.
//   lopd_8bit : d[7:0] -> vld (any bit set), pos (index of highest set bit)
//   lopd_32bit: d[31:0] -> vld, pos[4:0]; four octet detectors merged as
//               two 16-bit halves. pos is 0 when d == 0.
module lopd_8bit (
    input  logic [7:0] d,
    output logic       vld,
    output logic [2:0] pos
);
    always_comb begin
        vld = |d;
        pos = '0;
        // Ascending scan: the last hit is the highest set bit.
        for (int i = 0; i < 8; i++)
            if (d[i]) pos = 3'(i);
    end
endmodule

module lopd_32bit (
    input  logic [31:0] d,
    output logic        vld,
    output logic [4:0]  pos
);
    logic [3:0]      oct_vld;
    logic [3:0][2:0] oct_pos;
    logic            vld_h, vld_l;
    logic [3:0]      pos_h, pos_l;

    lopd_8bit u_oct [3:0] (.d(d), .vld(oct_vld), .pos(oct_pos));

    assign vld_h = oct_vld[3] | oct_vld[2];
    assign vld_l = oct_vld[1] | oct_vld[0];
    assign pos_h = oct_vld[3] ? {1'b1, oct_pos[3]} : {1'b0, oct_pos[2]};
    assign pos_l = oct_vld[1] ? {1'b1, oct_pos[1]} : {1'b0, oct_pos[0]};
    assign vld   = vld_h | vld_l;
    assign pos   = vld_h ? {1'b1, pos_h} : {1'b0, pos_l};
endmodule

// File: rtl/fp_add_norm_stage.sv
// FP32 add/sub post-add normalisation, 2-stage valid/ready pipeline.
//   S1: register raw sum, leading-one index, carry and zero flags.
//   S2: pick zero / carry / normal / subnormal case, barrel-shift, adjust exp.
// Ports:
//   i_clk, i_rst_n (async, active low)
//   i_valid/o_ready : upstream handshake; i_sign, i_exp, i_mant (raw sum,
//                     bit MANT_W = carry-out)
//   o_valid/i_ready : downstream handshake; o_sign, o_exp, o_mant,
//                     o_zero, o_underflow, o_overflow
module fp_add_norm_stage
    import fp_add_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_sign,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [MANT_W:0]   i_mant,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-1:0] o_mant,
    output logic              o_zero,
    output logic              o_underflow,
    output logic              o_overflow
);
    localparam int PAD = 32 - MANT_W;

    logic [2:1]  vld_pipe;
    logic        s1_adv;
    norm_beat_t  beat_in, s1;
    logic        lopd_vld;
    logic [4:0]  lopd_pos;

    // Mantissa sits at the top of the detector, so subtract the pad.
    lopd_32bit u_lopd (
        .d   ({i_mant[MANT_W-1:0], {PAD{1'b0}}}),
        .vld (lopd_vld),
        .pos (lopd_pos)
    );

    assign beat_in.sign  = i_sign;
    assign beat_in.exp   = i_exp;
    assign beat_in.mant  = i_mant[MANT_W-1:0];
    assign beat_in.carry = i_mant[MANT_W];
    assign beat_in.zero  = ~i_mant[MANT_W] & ~lopd_vld;
    assign beat_in.pos   = POS_W'(lopd_pos - 5'(PAD));

    assign s1_adv  = ~vld_pipe[2] | i_ready;
    assign o_ready = ~vld_pipe[1] | s1_adv;
    assign o_valid = vld_pipe[2];

    // ---- S2 combinational ----
    logic [EXP_W:0]         exp_ext, lz_ext, exp_inc, exp_norm;
    logic [POS_W-1:0]       lz, sub_sh, shamt;
    logic                   is_norm;
    logic [POS_W:0][MANT_W-1:0] sh_stg;

    assign exp_ext  = {1'b0, s1.exp};
    assign lz       = POS_W'(MANT_W-1) - s1.pos;
    assign lz_ext   = (EXP_W+1)'(lz);
    assign exp_inc  = exp_ext + (EXP_W+1)'(1);
    assign exp_norm = exp_ext - lz_ext;
    assign is_norm  = exp_ext > lz_ext;
    // Subnormal lands at exponent 1 (encoded 0); exp <= lz keeps this < lz.
    assign sub_sh   = (s1.exp == '0) ? '0 : POS_W'(s1.exp - EXP_W'(1));
    assign shamt    = is_norm ? lz : sub_sh;

    assign sh_stg[0] = s1.mant;
    for (genvar k = 0; k < POS_W; k++) begin : g_shl
        assign sh_stg[k+1] = shamt[k] ? (sh_stg[k] << (2**k)) : sh_stg[k];
    end

    logic              n_sign, n_zero, n_uf, n_of;
    logic [EXP_W-1:0]  n_exp;
    logic [MANT_W-1:0] n_mant;

    always_comb begin
        n_sign = s1.sign;
        n_exp  = '0;
        n_mant = '0;
        n_zero = 1'b0;
        n_uf   = 1'b0;
        n_of   = 1'b0;
        if (s1.zero) begin
            n_sign = 1'b0;          // exact cancellation rounds to +0
            n_zero = 1'b1;
        end else if (s1.carry) begin
            if (exp_inc == {1'b0, EXP_MAX}) begin
                n_of  = 1'b1;
                n_exp = EXP_MAX;
            end else begin
                n_exp  = exp_inc[EXP_W-1:0];
                // Dropped LSB folds into sticky.
                n_mant = {1'b1, s1.mant[MANT_W-1:1]} | MANT_W'(s1.mant[0]);
            end
        end else if (is_norm) begin
            n_exp  = exp_norm[EXP_W-1:0];
            n_mant = sh_stg[POS_W];
        end else begin
            n_uf   = 1'b1;
            n_mant = sh_stg[POS_W];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe    <= '0;
            s1          <= '0;
            o_sign      <= 1'b0;
            o_exp       <= '0;
            o_mant      <= '0;
            o_zero      <= 1'b0;
            o_underflow <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            if (o_ready) begin
                vld_pipe[1] <= i_valid;
                if (i_valid) s1 <= beat_in;
            end
            if (s1_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    o_sign      <= n_sign;
                    o_exp       <= n_exp;
                    o_mant      <= n_mant;
                    o_zero      <= n_zero;
                    o_underflow <= n_uf;
                    o_overflow  <= n_of;
                end
            end
        end
    end
endmodule
